// File: rtl/apb_intc_vectored_if.sv
// APB3 bus bundle for apb_intc_vectored; the clock and reset stay plain ports on the controller.
interface apb_intc_vectored_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [5:2]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA
  );
endinterface

// File: rtl/apb_intc_vectored.sv
// Vectored APB3 interrupt controller with per-source edge/level mode, polarity and soft raise.
// Define APB_INTC_SYNC_EN to put a two-flop synchroniser on irq_src.
module apb_intc_vectored #(
  parameter int unsigned NUM_SRC      = 8,
  parameter bit          IRQ_POLARITY = 1'b0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_intc_vectored_if.slave    bus,
  input  logic [NUM_SRC-1:0]    irq_src,
  output logic                  IRQ,
  output logic [4:0]            IRQ_ID
);

  localparam logic [31:0] ImplMask = (NUM_SRC >= 32) ? 32'hFFFF_FFFF :
                                     ((32'd1 << NUM_SRC) - 32'd1);

  logic [31:0] en_q, en_d, mode_q, mode_d, pol_q, pol_d, soft_q, soft_d;
  logic [31:0] s_q, s_d, s_prev_q, edge_lat_q, edge_lat_d, prdata_q, prdata_d;
  logic        irq_q, irq_d;
  logic [4:0]  irq_id_q, irq_id_d;

  logic [31:0] src_ext, wdata, ack_vec, pend_clr, edge_set, pending, masked, rdata;
  logic [4:0]  vec;
  logic        any, wr_en, rd_en;

`ifdef APB_INTC_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign src_ext = 32'(sync2_q);
`else
  assign src_ext = 32'(irq_src);
`endif

  assign wr_en   = bus.PSEL & bus.PWRITE & ~bus.PENABLE;
  assign rd_en   = bus.PSEL & ~bus.PWRITE & ~bus.PENABLE;
  assign wdata   = bus.PWDATA & ImplMask;
  assign ack_vec = ({27'd0, bus.PWDATA[4:0]} < NUM_SRC) ? (32'd1 << bus.PWDATA[4:0]) : 32'd0;

  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    pol_d    = pol_q;
    soft_d   = soft_q;
    pend_clr = 32'd0;
    if (wr_en) begin
      case (bus.PADDR)
        4'h0: en_d = en_q | wdata;
        4'h1: en_d = en_q & ~wdata;
        4'h2: mode_d = wdata;
        4'h3: pol_d = wdata;
        4'h5: pend_clr = wdata;
        4'h6: soft_d = soft_q | wdata;
        4'h7: soft_d = soft_q & ~wdata;
        4'hA: begin
          pend_clr = ack_vec;
          soft_d   = soft_q & ~ack_vec;
        end
        default: ;
      endcase
    end
  end

  // A fresh edge outranks a same-cycle clear; a level-mode bit never holds a latch.
  assign s_d        = (src_ext ^ pol_q) & ImplMask;
  assign edge_set   = mode_q & s_q & ~s_prev_q;
  assign edge_lat_d = mode_q & (edge_set | (edge_lat_q & ~pend_clr));
  assign pending    = edge_lat_q | (~mode_q & s_q) | soft_q;
  assign masked     = pending & en_q;
  assign any        = |masked;

  always_comb begin
    vec = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (masked[i]) vec = 5'(i);
    end
  end

  assign irq_d    = any ^ ~IRQ_POLARITY;
  assign irq_id_d = any ? vec : irq_id_q;

  always_comb begin
    rdata = 32'd0;
    case (bus.PADDR)
      4'h0, 4'h1: rdata = en_q;
      4'h2:       rdata = mode_q;
      4'h3:       rdata = pol_q;
      4'h4:       rdata = s_q;
      4'h5:       rdata = pending;
      4'h6, 4'h7: rdata = soft_q;
      4'h8:       rdata = masked;
      4'h9:       rdata = {any, 26'd0, vec};
      default:    rdata = 32'd0;
    endcase
  end

  assign prdata_d = rd_en ? rdata : 32'd0;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      en_q       <= 32'd0;
      mode_q     <= 32'd0;
      pol_q      <= 32'd0;
      soft_q     <= 32'd0;
      s_q        <= 32'd0;
      s_prev_q   <= 32'd0;
      edge_lat_q <= 32'd0;
      prdata_q   <= 32'd0;
      irq_q      <= ~IRQ_POLARITY;
      irq_id_q   <= 5'd0;
    end else begin
      en_q       <= en_d;
      mode_q     <= mode_d;
      pol_q      <= pol_d;
      soft_q     <= soft_d;
      s_q        <= s_d;
      s_prev_q   <= s_q;
      edge_lat_q <= edge_lat_d;
      prdata_q   <= prdata_d;
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
    end
  end

  assign bus.PRDATA = prdata_q;
  assign IRQ        = irq_q;
  assign IRQ_ID     = irq_id_q;

endmodule

// File: tb/tb_apb_intc_vectored.sv
// Scoreboard bench for apb_intc_vectored: an 8-source and a 4-source instance share one bus stream.
module tb_apb_intc_vectored;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [7:0]  irq_src;
  logic        irq8, irq4;
  logic [4:0]  id8, id4;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];

  apb_intc_vectored_if bus ();
  apb_intc_vectored_if bus4 ();

  assign bus4.PSEL    = bus.PSEL;
  assign bus4.PENABLE = bus.PENABLE;
  assign bus4.PWRITE  = bus.PWRITE;
  assign bus4.PADDR   = bus.PADDR;
  assign bus4.PWDATA  = bus.PWDATA;

  apb_intc_vectored #(.NUM_SRC(8), .IRQ_POLARITY(1'b0)) u_dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .bus     (bus),
    .irq_src (irq_src),
    .IRQ     (irq8),
    .IRQ_ID  (id8)
  );

  apb_intc_vectored #(.NUM_SRC(4), .IRQ_POLARITY(1'b0)) u_dut4 (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .bus     (bus4),
    .irq_src (irq_src[3:0]),
    .IRQ     (irq4),
    .IRQ_ID  (id4)
  );

  always #5 PCLK = ~PCLK;

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = a; bus.PWDATA = d;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  // Samples PRDATA in the access phase, from the 4-source instance when use4 is set.
  task automatic apb_read(input logic [3:0] a, input bit use4, output logic [31:0] got);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PENABLE = 1'b0; bus.PADDR = a;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    got = use4 ? bus4.PRDATA : bus.PRDATA;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got, e;
    PRESET = 1'b1;
    #12;
    total++; if (irq8 !== 1'b1) begin bad++; $display("FAIL rst_irq: got=%b exp=1", irq8); end
    total++; if (id8 !== 5'd0) begin bad++; $display("FAIL rst_id: got=%0d exp=0", id8); end
    total++; if (bus.PRDATA !== 32'd0) begin
      bad++; $display("FAIL rst_prdata: got=%h exp=0", bus.PRDATA);
    end
    @(negedge PCLK); PRESET = 1'b0;
    for (int a = 0; a < 16; a++) begin
      exp_q.push_back(32'd0);
      apb_read(4'(a), 1'b0, got);
      e = exp_q.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL rst_reg%0d: got=%h exp=%h", a, got, e); end
      total++; if (bus.PRDATA !== 32'd0) begin
        bad++; $display("FAIL prdata_idle: got=%h exp=0", bus.PRDATA);
      end
    end
  endtask

  task automatic test_level();
    logic [31:0] got, e;
    apb_write(4'h0, 32'h04);
    irq_src[2] = 1'b1;
    @(posedge PCLK); #1;
    total++; if (irq8 !== 1'b1) begin bad++; $display("FAIL lvl_early: got=%b exp=1", irq8); end
    @(posedge PCLK); #1;
    total++; if (irq8 !== 1'b0) begin bad++; $display("FAIL lvl_irq: got=%b exp=0", irq8); end
    total++; if (id8 !== 5'd2) begin bad++; $display("FAIL lvl_id: got=%0d exp=2", id8); end
    exp_q.push_back(32'h8000_0002);
    apb_read(4'h9, 1'b0, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL lvl_vector: got=%h exp=%h", got, e); end
    exp_q.push_back(32'h04);
    apb_read(4'h4, 1'b0, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL lvl_raw: got=%h exp=%h", got, e); end
    // Level bits survive a PENDING W1C.
    apb_write(4'h5, 32'h04);
    exp_q.push_back(32'h04);
    apb_read(4'h5, 1'b0, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL lvl_noclr: got=%h exp=%h", got, e); end
    irq_src[2] = 1'b0;
    @(posedge PCLK); #1;
    total++; if (irq8 !== 1'b0) begin bad++; $display("FAIL lvl_hold: got=%b exp=0", irq8); end
    @(posedge PCLK); #1;
    total++; if (irq8 !== 1'b1) begin bad++; $display("FAIL lvl_drop: got=%b exp=1", irq8); end
    apb_write(4'h1, 32'h04);
    exp_q.push_back(32'h00);
    apb_read(4'h0, 1'b0, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL en_clr: got=%h exp=%h", got, e); end
  endtask

  task automatic test_edge();
    logic [31:0] got, e;
    apb_write(4'h2, 32'h01);
    apb_write(4'h0, 32'h01);
    irq_src[0] = 1'b1;
    @(posedge PCLK); #1;
    irq_src[0] = 1'b0;
    @(posedge PCLK); #1;
    total++; if (irq8 !== 1'b1) begin bad++; $display("FAIL edge_early: got=%b exp=1", irq8); end
    @(posedge PCLK); #1;
    total++; if (irq8 !== 1'b0) begin bad++; $display("FAIL edge_irq: got=%b exp=0", irq8); end
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(32'h01);
      apb_read(4'h5, 1'b0, got);
      e = exp_q.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL edge_pend%0d: got=%h exp=%h", k, got, e); end
    end
    apb_write(4'hA, 32'h00);
    total++; if (irq8 !== 1'b1) begin bad++; $display("FAIL edge_ack_irq: got=%b exp=1", irq8); end
    exp_q.push_back(32'h00);
    apb_read(4'h5, 1'b0, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL edge_ack_pend: got=%h exp=%h", got, e); end
  endtask

  task automatic test_priority();
    logic [31:0] got, e;
    apb_write(4'h2, 32'h28);
    apb_write(4'h0, 32'h28);
    irq_src[5] = 1'b1; irq_src[3] = 1'b1;
    @(posedge PCLK); #1;
    irq_src[5] = 1'b0; irq_src[3] = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    total++; if (id8 !== 5'd3) begin bad++; $display("FAIL prio_id: got=%0d exp=3", id8); end
    apb_write(4'hA, 32'h03);
    total++; if (id8 !== 5'd5) begin bad++; $display("FAIL prio_ack3: got=%0d exp=5", id8); end
    exp_q.push_back(32'h20);
    apb_read(4'h5, 1'b0, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL prio_pend: got=%h exp=%h", got, e); end
    apb_write(4'hA, 32'h05);
    total++; if (irq8 !== 1'b1) begin bad++; $display("FAIL prio_idle: got=%b exp=1", irq8); end
    total++; if (id8 !== 5'd5) begin bad++; $display("FAIL prio_hold: got=%0d exp=5", id8); end
  endtask

  task automatic test_soft();
    logic [31:0] got, e;
    apb_write(4'h0, 32'h80);
    apb_write(4'h6, 32'h80);
    total++; if (id8 !== 5'd7 || irq8 !== 1'b0) begin
      bad++; $display("FAIL soft_irq: got id=%0d irq=%b exp id=7 irq=0", id8, irq8);
    end
    exp_q.push_back(32'h80);
    apb_read(4'h6, 1'b0, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL soft_rd: got=%h exp=%h", got, e); end
    apb_write(4'hA, 32'h07);
    exp_q.push_back(32'h00);
    apb_read(4'h7, 1'b0, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL soft_ack: got=%h exp=%h", got, e); end
    total++; if (irq8 !== 1'b1) begin bad++; $display("FAIL soft_idle: got=%b exp=1", irq8); end
  endtask

  task automatic test_collision();
    logic [31:0] got, e;
    apb_write(4'h2, 32'h02);
    irq_src[1] = 1'b1;
    @(posedge PCLK); #1;
    // s_q rose on the last edge; the W1C strobe lands on the same edge as the latch set.
    irq_src[1] = 1'b0;
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = 4'h5; bus.PWDATA = 32'h02;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    exp_q.push_back(32'h02);
    apb_read(4'h5, 1'b0, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL coll_setwins: got=%h exp=%h", got, e); end
    apb_write(4'h5, 32'h02);
    exp_q.push_back(32'h00);
    apb_read(4'h5, 1'b0, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL coll_w1c: got=%h exp=%h", got, e); end
  endtask

  task automatic test_num_src();
    logic [31:0] got, e;
    apb_write(4'h0, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0F);
    apb_read(4'h0, 1'b1, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL ns4_en: got=%h exp=%h", got, e); end
    exp_q.push_back(32'hFF);
    apb_read(4'h0, 1'b0, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL ns8_en: got=%h exp=%h", got, e); end
    apb_write(4'h6, 32'h89);
    apb_write(4'hA, 32'h1F);
    exp_q.push_back(32'h89);
    apb_read(4'h6, 1'b0, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL ns8_ack1f: got=%h exp=%h", got, e); end
    exp_q.push_back(32'h09);
    apb_read(4'h6, 1'b1, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL ns4_ack1f: got=%h exp=%h", got, e); end
    total++; if (id4 !== 5'd0 || irq4 !== 1'b0) begin
      bad++; $display("FAIL ns4_irq: got id=%0d irq=%b exp id=0 irq=0", id4, irq4);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, e;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PENABLE = 1'b0; bus.PADDR = 4'h0;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    total++; if (bus.PRDATA !== 32'hFF) begin
      bad++; $display("FAIL mid_prdata: got=%h exp=000000ff", bus.PRDATA);
    end
    PRESET = 1'b1;
    #1;
    total++; if (bus.PRDATA !== 32'd0 || irq8 !== 1'b1 || id8 !== 5'd0) begin
      bad++; $display("FAIL mid_rst: got prdata=%h irq=%b id=%0d exp 0/1/0", bus.PRDATA, irq8, id8);
    end
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    @(negedge PCLK); PRESET = 1'b0;
    exp_q.push_back(32'h00);
    apb_read(4'h6, 1'b0, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL mid_soft: got=%h exp=%h", got, e); end
  endtask

  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 4'h0; bus.PWDATA = 32'd0;
    irq_src = 8'h00;
    test_reset();
    test_level();
    test_edge();
    test_priority();
    test_soft();
    test_collision();
    test_num_src();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
